// File: rtl/lsu_seq.sv
// lsu_seq: one load/store/CSR/register op per request, IDLE -> BUS -> RESP, on a wait-state data bus.
// Define LSU_MISALIGN_EXC_EN to trap misaligned half/word accesses instead of truncating the address.
package lsu_seq_pkg;
   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_LB    = 4'd1,
      OP_LH    = 4'd2,
      OP_LW    = 4'd3,
      OP_LBU   = 4'd4,
      OP_LHU   = 4'd5,
      OP_SB    = 4'd6,
      OP_SH    = 4'd7,
      OP_SW    = 4'd8,
      OP_CSRR  = 4'd9,
      OP_CSRRW = 4'd10,
      OP_REG   = 4'd11
   } lsu_op_t;

   typedef logic [4:0] gpr_addr_t;
endpackage

module lsu_seq
   import lsu_seq_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  lsu_op_t     lsu_op,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic [31:0] alt_data,
   input  logic        endianness,
   input  gpr_addr_t   dest_addr,
   output logic        resp_valid,
   output logic        dest_en,
   output gpr_addr_t   dest_addr_o,
   output logic [31:0] dest_data,
   output logic        exc,
   output logic [3:0]  exc_cause,
   output logic        csr_wr_en,
   output logic [31:0] csr_wr_data,
   output logic        dbus_rd_en,
   output logic        dbus_wr_en,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wr_data,
   output logic [3:0]  dbus_wr_strobe,
   input  logic [31:0] dbus_rd_data,
   input  logic        dbus_wait,
   input  logic        dbus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

`ifdef LSU_MISALIGN_EXC_EN
   localparam logic MIS_TRAP = 1'b1;
`else
   localparam logic MIS_TRAP = 1'b0;
`endif

   localparam logic [31:0] TO_LIM = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   function automatic logic [1:0] op_size(input lsu_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
         OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
         default:              op_size = 2'd2;
      endcase
   endfunction

   function automatic logic [3:0] base_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    base_mask = 4'h1;
         2'd1:    base_mask = 4'h3;
         default: base_mask = 4'hF;
      endcase
   endfunction

   // Keep only the bytes of the access size, byte-swapped within that size when big-endian.
   function automatic logic [31:0] fit(input logic [31:0] d, input logic [1:0] sz, input logic be);
      case (sz)
         2'd0:    fit = {24'h0, d[7:0]};
         2'd1:    fit = be ? {16'h0, d[7:0], d[15:8]} : {16'h0, d[15:0]};
         default: fit = be ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic sx);
      case (sz)
         2'd0:    extend = {{24{sx & d[7]}}, d[7:0]};
         2'd1:    extend = {{16{sx & d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   state_t      state_q;
   logic [31:0] wait_cnt_q;
   logic [1:0]  sz_q, off_q;
   logic        be_q, ld_q, sx_q;
   gpr_addr_t   dest_q;

   logic        req_ready_q, resp_valid_q, dest_en_q, exc_q, csr_wr_en_q;
   logic        dbus_rd_en_q, dbus_wr_en_q;
   gpr_addr_t   dest_addr_o_q;
   logic [31:0] dest_data_q, csr_wr_data_q, dbus_addr_q, dbus_wr_data_q;
   logic [3:0]  exc_cause_q, dbus_wr_strobe_q;

   logic [1:0]  sz_d, off_d;
   logic        load_d, mem_d, mis_d, mis_trap_d, nm_en_d, abort_d;
   logic [3:0]  strobe_d;
   logic [31:0] wdata_d, nm_data_d, ld_d;

   // Decode of the incoming request: lanes, store data, misalignment and non-memory result.
   always_comb begin
      sz_d   = op_size(lsu_op);
      load_d = lsu_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
      mem_d  = load_d || (lsu_op inside {OP_SB, OP_SH, OP_SW});
      off_d  = addr[1:0];
      mis_d  = 1'b0;
      case (sz_d)
         2'd0:    mis_d = 1'b0;
         2'd1:    begin off_d = {addr[1], 1'b0}; mis_d = addr[0]; end
         default: begin off_d = 2'b00; mis_d = |addr[1:0]; end
      endcase
      strobe_d   = base_mask(sz_d) << off_d;
      wdata_d    = fit(wr_data, sz_d, endianness) << {off_d, 3'b000};
      mis_trap_d = MIS_TRAP && mem_d && mis_d;
      nm_en_d    = 1'b0;
      nm_data_d  = 32'd0;
      case (lsu_op)
         OP_CSRR, OP_CSRRW: begin nm_en_d = 1'b1; nm_data_d = alt_data; end
         OP_REG:            begin nm_en_d = 1'b1; nm_data_d = addr; end
         default:           begin nm_en_d = 1'b0; nm_data_d = 32'd0; end
      endcase
   end

   // Bus-side decode: abort condition (error beats wait) and formatted load data.
   always_comb begin
      abort_d = dbus_err;
      if (TIMEOUT > 0) begin
         abort_d = dbus_err || (dbus_wait && (wait_cnt_q == TO_LIM));
      end else begin
         abort_d = dbus_err;
      end
      ld_d = extend(fit(dbus_rd_data >> {off_q, 3'b000}, sz_q, be_q), sz_q, sx_q);
   end

   // Sequencer FSM; every output is a register written here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         wait_cnt_q       <= 32'd0;
         sz_q             <= 2'd0;
         off_q            <= 2'd0;
         be_q             <= 1'b0;
         ld_q             <= 1'b0;
         sx_q             <= 1'b0;
         dest_q           <= '0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         dest_en_q        <= 1'b0;
         dest_addr_o_q    <= '0;
         dest_data_q      <= 32'd0;
         exc_q            <= 1'b0;
         exc_cause_q      <= 4'd0;
         csr_wr_en_q      <= 1'b0;
         csr_wr_data_q    <= 32'd0;
         dbus_rd_en_q     <= 1'b0;
         dbus_wr_en_q     <= 1'b0;
         dbus_addr_q      <= 32'd0;
         dbus_wr_data_q   <= 32'd0;
         dbus_wr_strobe_q <= 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  sz_q        <= sz_d;
                  off_q       <= off_d;
                  be_q        <= endianness;
                  ld_q        <= load_d;
                  sx_q        <= (lsu_op == OP_LB) || (lsu_op == OP_LH);
                  dest_q      <= dest_addr;
                  wait_cnt_q  <= 32'd0;
                  if (mem_d && !mis_trap_d) begin
                     state_q          <= S_BUS;
                     dbus_rd_en_q     <= load_d;
                     dbus_wr_en_q     <= !load_d;
                     dbus_addr_q      <= {addr[31:2], 2'b00};
                     dbus_wr_data_q   <= load_d ? 32'd0 : wdata_d;
                     dbus_wr_strobe_q <= load_d ? 4'd0 : strobe_d;
                  end else begin
                     state_q       <= S_RESP;
                     resp_valid_q  <= 1'b1;
                     dest_addr_o_q <= dest_addr;
                     exc_q         <= mem_d;
                     exc_cause_q   <= mem_d ? (load_d ? 4'd4 : 4'd6) : 4'd0;
                     dest_en_q     <= nm_en_d;
                     dest_data_q   <= nm_data_d;
                     csr_wr_en_q   <= (lsu_op == OP_CSRRW);
                     csr_wr_data_q <= (lsu_op == OP_CSRRW) ? addr : 32'd0;
                  end
               end
            end
            S_BUS: begin
               if (abort_d || !dbus_wait) begin
                  state_q          <= S_RESP;
                  dbus_rd_en_q     <= 1'b0;
                  dbus_wr_en_q     <= 1'b0;
                  dbus_addr_q      <= 32'd0;
                  dbus_wr_data_q   <= 32'd0;
                  dbus_wr_strobe_q <= 4'd0;
                  resp_valid_q     <= 1'b1;
                  dest_addr_o_q    <= dest_q;
                  exc_q            <= abort_d;
                  exc_cause_q      <= abort_d ? (ld_q ? 4'd5 : 4'd7) : 4'd0;
                  dest_en_q        <= ld_q && !abort_d;
                  dest_data_q      <= (ld_q && !abort_d) ? ld_d : 32'd0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 32'd1;
               end
            end
            default: begin
               state_q          <= S_IDLE;
               req_ready_q      <= 1'b1;
               resp_valid_q     <= 1'b0;
               dest_en_q        <= 1'b0;
               dest_addr_o_q    <= '0;
               dest_data_q      <= 32'd0;
               exc_q            <= 1'b0;
               exc_cause_q      <= 4'd0;
               csr_wr_en_q      <= 1'b0;
               csr_wr_data_q    <= 32'd0;
               dbus_rd_en_q     <= 1'b0;
               dbus_wr_en_q     <= 1'b0;
               dbus_addr_q      <= 32'd0;
               dbus_wr_data_q   <= 32'd0;
               dbus_wr_strobe_q <= 4'd0;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign dest_en        = dest_en_q;
   assign dest_addr_o    = dest_addr_o_q;
   assign dest_data      = dest_data_q;
   assign exc            = exc_q;
   assign exc_cause      = exc_cause_q;
   assign csr_wr_en      = csr_wr_en_q;
   assign csr_wr_data    = csr_wr_data_q;
   assign dbus_rd_en     = dbus_rd_en_q;
   assign dbus_wr_en     = dbus_wr_en_q;
   assign dbus_addr      = dbus_addr_q;
   assign dbus_wr_data   = dbus_wr_data_q;
   assign dbus_wr_strobe = dbus_wr_strobe_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Bench for lsu_seq: random and directed requests, every cycle compared with a transaction-level
// model of byte lanes, latency and exceptions; a few literal expectations pin the model.
`timescale 1ns/1ps
module tb_lsu_seq;
   import lsu_seq_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst, req_valid, endianness, dbus_wait, dbus_err;
   lsu_op_t     lsu_op;
   logic [31:0] addr, wr_data, alt_data, dbus_rd_data;
   gpr_addr_t   dest_addr;
   logic        req_ready, resp_valid, dest_en, exc, csr_wr_en, dbus_rd_en, dbus_wr_en;
   gpr_addr_t   dest_addr_o;
   logic [31:0] dest_data, csr_wr_data, dbus_addr, dbus_wr_data;
   logic [3:0]  exc_cause, dbus_wr_strobe;

   always #5 clk = ~clk;

   lsu_seq #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .lsu_op(lsu_op), .addr(addr), .wr_data(wr_data), .alt_data(alt_data),
      .endianness(endianness), .dest_addr(dest_addr),
      .resp_valid(resp_valid), .dest_en(dest_en), .dest_addr_o(dest_addr_o), .dest_data(dest_data),
      .exc(exc), .exc_cause(exc_cause), .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data),
      .dbus_rd_en(dbus_rd_en), .dbus_wr_en(dbus_wr_en), .dbus_addr(dbus_addr),
      .dbus_wr_data(dbus_wr_data), .dbus_wr_strobe(dbus_wr_strobe),
      .dbus_rd_data(dbus_rd_data), .dbus_wait(dbus_wait), .dbus_err(dbus_err)
   );

   lsu_op_t ops [12] = '{OP_NOP, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                         OP_SB, OP_SH, OP_SW, OP_CSRR, OP_CSRRW, OP_REG};

   // Expected outputs for the current cycle, written by the driver.
   logic        e_ready, e_resp, e_den, e_exc, e_csr, e_rd, e_wr;
   gpr_addr_t   e_dst;
   logic [31:0] e_dd, e_csrd, e_daddr, e_wd;
   logic [3:0]  e_cause, e_stb;
   // Hand-computed literals for directed requests.
   logic        pa_en, pw_en, pd_en, pc_en;
   logic [31:0] pa, pw, pd;
   logic [3:0]  ps, pc;
   logic        chk_en;
   int          n_cmp, n_bad;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: dut=%h model=%h t=%0t", nm, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("resp_valid", 32'(resp_valid), 32'(e_resp));
         chk("dest_en", 32'(dest_en), 32'(e_den));
         chk("exc", 32'(exc), 32'(e_exc));
         chk("csr_wr_en", 32'(csr_wr_en), 32'(e_csr));
         chk("dbus_rd_en", 32'(dbus_rd_en), 32'(e_rd));
         chk("dbus_wr_en", 32'(dbus_wr_en), 32'(e_wr));
         if (e_rd || e_wr) chk("dbus_addr", dbus_addr, e_daddr);
         if (e_wr) chk("dbus_wr_data", dbus_wr_data, e_wd);
         if (e_wr) chk("dbus_wr_strobe", 32'(dbus_wr_strobe), 32'(e_stb));
         if (e_den) chk("dest_data", dest_data, e_dd);
         if (e_den) chk("dest_addr_o", 32'(dest_addr_o), 32'(e_dst));
         if (e_exc) chk("exc_cause", 32'(exc_cause), 32'(e_cause));
         if (e_csr) chk("csr_wr_data", csr_wr_data, e_csrd);
         if (pa_en && (e_rd || e_wr)) chk("lit_addr", dbus_addr, pa);
         if (pw_en && e_wr) chk("lit_wr_data", dbus_wr_data, pw);
         if (pw_en && e_wr) chk("lit_strobe", 32'(dbus_wr_strobe), 32'(ps));
         if (pd_en && e_resp) chk("lit_dest_data", dest_data, pd);
         if (pc_en && e_resp) chk("lit_cause", 32'(exc_cause), 32'(pc));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_exp();
      e_ready = 1'b0; e_resp = 1'b0; e_den = 1'b0; e_exc = 1'b0; e_csr = 1'b0;
      e_rd = 1'b0; e_wr = 1'b0; e_dst = '0; e_dd = 32'd0; e_csrd = 32'd0;
      e_daddr = 32'd0; e_wd = 32'd0; e_cause = 4'd0; e_stb = 4'd0;
   endtask

   task automatic set_idle();
      clr_exp();
      e_ready = 1'b1;
   endtask

   task automatic clr_pins();
      pa_en = 1'b0; pw_en = 1'b0; pd_en = 1'b0; pc_en = 1'b0;
      pa = 32'd0; pw = 32'd0; pd = 32'd0; ps = 4'd0; pc = 4'd0;
   endtask

   task automatic junk_req();
      req_valid  = 1'($urandom_range(0, 1));
      lsu_op     = ops[$urandom_range(0, 11)];
      addr       = $urandom;
      wr_data    = $urandom;
      alt_data   = $urandom;
      endianness = 1'($urandom_range(0, 1));
      dest_addr  = gpr_addr_t'($urandom_range(0, 31));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         set_idle();
         req_valid = 1'b0;
         dbus_wait = 1'b0;
         dbus_err  = 1'b0;
         cyc();
      end
   endtask

   // One complete request: bus plan is nwait wait cycles, then a final cycle (optionally erroring).
   task automatic do_req(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] alt, input logic be, input gpr_addr_t dst,
                         input int nwait, input bit err, input logic [31:0] rd);
      int nb, off, nbus;
      bit ld, st, sgn, mis, tmo, fail, last;
      logic [31:0] m_wd, m_ld;
      logic [3:0]  m_stb;
      ld  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
      st  = op inside {OP_SB, OP_SH, OP_SW};
      sgn = (op == OP_LB) || (op == OP_LH);
      nb  = (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
      off = (nb == 1) ? int'(a[1:0]) : (nb == 2) ? 2 * int'(a[1]) : 0;
`ifdef LSU_MISALIGN_EXC_EN
      mis = (ld || st) && ((nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00));
`else
      mis = 1'b0;
`endif
      m_wd = 32'd0; m_ld = 32'd0; m_stb = 4'd0;
      for (int i = 0; i < nb; i++) begin
         int lane, src;
         lane = off + i;
         src  = be ? nb - 1 - i : i;
         m_wd = m_wd | (((wd >> (8 * src)) & 32'hFF) << (8 * lane));
         m_stb[lane] = 1'b1;
         m_ld = m_ld | (((rd >> (8 * lane)) & 32'hFF) << (8 * src));
      end
      if (sgn && nb < 4 && m_ld[8 * nb - 1]) m_ld = m_ld | (32'hFFFF_FFFF << (8 * nb));
      tmo  = (TO > 0) && (nwait >= TO);
      nbus = (!(ld || st) || mis) ? 0 : (tmo ? TO : nwait + 1);
      fail = (ld || st) && (mis || tmo || err);

      set_idle();
      req_valid = 1'b1; lsu_op = op; addr = a; wr_data = wd; alt_data = alt;
      endianness = be; dest_addr = dst; dbus_wait = 1'b0; dbus_err = 1'b0;
      cyc();
      for (int k = 0; k < nbus; k++) begin
         clr_exp();
         e_rd = ld; e_wr = st; e_daddr = {a[31:2], 2'b00}; e_wd = m_wd; e_stb = m_stb;
         junk_req();
         last         = (k == nbus - 1) && !tmo;
         dbus_err     = last && err;
         dbus_wait    = last ? (err ? 1'($urandom_range(0, 1)) : 1'b0) : 1'b1;
         dbus_rd_data = last ? rd : $urandom;
         cyc();
      end
      clr_exp();
      e_resp = 1'b1; e_dst = dst; e_exc = fail;
      e_cause = mis ? (ld ? 4'd4 : 4'd6) : (ld ? 4'd5 : 4'd7);
      if (ld && !fail) begin e_den = 1'b1; e_dd = m_ld; end
      if (op == OP_CSRR || op == OP_CSRRW) begin e_den = 1'b1; e_dd = alt; end
      if (op == OP_REG) begin e_den = 1'b1; e_dd = a; end
      if (op == OP_CSRRW) begin e_csr = 1'b1; e_csrd = a; end
      junk_req();
      dbus_wait = 1'($urandom_range(0, 1)); dbus_err = 1'($urandom_range(0, 1));
      dbus_rd_data = $urandom;
      cyc();
      clr_pins();
   endtask

   task automatic reset_mid_bus();
      set_idle();
      req_valid = 1'b1; lsu_op = OP_LW; addr = 32'h4000; wr_data = 32'd0; alt_data = 32'd0;
      endianness = 1'b0; dest_addr = 5'd3; dbus_wait = 1'b0; dbus_err = 1'b0;
      cyc();
      clr_exp();
      e_rd = 1'b1; e_daddr = 32'h4000;
      req_valid = 1'b0; dbus_wait = 1'b1; rst = 1'b1;
      cyc();
      set_idle();
      rst = 1'b0;
      cyc();
      idle(2);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; chk_en = 1'b0;
      rst = 1'b1; req_valid = 1'b0; lsu_op = OP_NOP; addr = 32'd0; wr_data = 32'd0;
      alt_data = 32'd0; endianness = 1'b0; dest_addr = '0; dbus_rd_data = 32'd0;
      dbus_wait = 1'b0; dbus_err = 1'b0;
      clr_pins();
      set_idle();
      cyc();
      chk_en = 1'b1;
      cyc();
      rst = 1'b0;
      idle(2);

      pa_en = 1'b1; pa = 32'h1000; pd_en = 1'b1; pd = 32'h1122_3344;
      do_req(OP_LW, 32'h1000, 32'd0, 32'd0, 1'b0, 5'd1, 0, 1'b0, 32'h1122_3344);
      pw_en = 1'b1; pw = 32'hAB00_0000; ps = 4'h8;
      do_req(OP_SB, 32'h2003, 32'h0000_00AB, 32'd0, 1'b0, 5'd2, 0, 1'b0, 32'd0);
      pd_en = 1'b1; pd = 32'hFFFF_8012;
      do_req(OP_LH, 32'h2002, 32'd0, 32'd0, 1'b1, 5'd3, 0, 1'b0, 32'h1280_0000);
      pw_en = 1'b1; pw = 32'h0000_3412; ps = 4'h3;
      do_req(OP_SH, 32'h2000, 32'h0000_1234, 32'd0, 1'b1, 5'd4, 1, 1'b0, 32'd0);
      do_req(OP_LW, 32'h1004, 32'd0, 32'd0, 1'b0, 5'd5, 3, 1'b0, 32'hDEAD_BEEF);
      pc_en = 1'b1; pc = 4'd7;
      do_req(OP_SW, 32'h5000, 32'h0BAD_F00D, 32'd0, 1'b0, 5'd6, 40, 1'b0, 32'd0);
      idle(1);
      pc_en = 1'b1; pc = 4'd5;
      do_req(OP_LB, 32'h6001, 32'd0, 32'd0, 1'b0, 5'd7, 2, 1'b1, 32'd0);
`ifdef LSU_MISALIGN_EXC_EN
      pc_en = 1'b1; pc = 4'd4;
`else
      pa_en = 1'b1; pa = 32'h3000; pd_en = 1'b1; pd = 32'hFFFF_BEEF;
`endif
      do_req(OP_LH, 32'h3001, 32'd0, 32'd0, 1'b0, 5'd8, 0, 1'b0, 32'h1234_BEEF);
      pd_en = 1'b1; pd = 32'h0000_0055;
      do_req(OP_CSRRW, 32'hCAFE_0001, 32'd0, 32'h0000_0055, 1'b0, 5'd9, 0, 1'b0, 32'd0);
      pd_en = 1'b1; pd = 32'h0000_1234;
      do_req(OP_REG, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 5'd10, 0, 1'b0, 32'd0);
      do_req(OP_NOP, 32'h0, 32'd0, 32'd0, 1'b0, 5'd11, 0, 1'b0, 32'd0);
      do_req(OP_CSRR, 32'h0, 32'd0, 32'h7777_0000, 1'b0, 5'd12, 0, 1'b0, 32'd0);
      reset_mid_bus();

      for (int n = 0; n < 250; n++) begin
         int nw;
         nw = ($urandom_range(0, 19) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
         do_req(ops[$urandom_range(0, 11)], $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), gpr_addr_t'($urandom_range(0, 31)),
                nw, ($urandom_range(0, 7) == 0), $urandom);
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
